// File: rtl/pulse_train_gen.sv
// pulse_train_gen: turns debounced button events into fixed-width pulses
// with a guaranteed low gap, queuing events that arrive mid-pulse.
//
// Ports:
//   cclk    - clock, rising edge
//   clr     - asynchronous active-high reset
//   trig    - debounced event level, each 0->1 edge is one event
//   clr_ovf - synchronous clear of the sticky overflow flag
//   outp    - registered pulse output (HIGH_CYC high, >= GAP_CYC low)
//   busy    - pulse/gap active or events still queued
//   pend    - number of queued events not yet launched
//   ovf     - sticky flag, set when an event is dropped on a full queue
module pulse_train_gen #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int PEND_W   = 3
) (
    input  logic              cclk,
    input  logic              clr,
    input  logic              trig,
    input  logic              clr_ovf,
    output logic              outp,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam int MAXC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]     HLOAD = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0]     GLOAD = CW'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PMAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              trig_q;
    logic              rise;
    logic              launch_ok;
    logic              launch;
    logic              sat;

    assign rise      = trig & ~trig_q;
    assign sat       = (pend == PMAX);

    // A new pulse may start from idle, or on the last gap cycle so the
    // low time is never stretched beyond GAP_CYC when work is queued.
    assign launch_ok = (state == IDLE) |
                       ((state == GAP) & (cnt == '0));
    assign launch    = launch_ok & ((pend != '0) | rise);

    assign busy      = (state != IDLE) | (pend != '0);

    // Pulse FSM; outp is loaded with (next state == HIGH) so it is a
    // clean register output that tracks the HIGH state exactly.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            trig_q <= 1'b0;
            outp   <= 1'b0;
        end else begin
            trig_q <= trig;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= HIGH;
                        cnt   <= HLOAD;
                        outp  <= 1'b1;
                    end else begin
                        outp  <= 1'b0;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= GLOAD;
                        outp  <= 1'b0;
                    end else begin
                        cnt   <= cnt - CW'(1);
                        outp  <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt   <= cnt - CW'(1);
                        outp  <= 1'b0;
                    end else if (launch) begin
                        state <= HIGH;
                        cnt   <= HLOAD;
                        outp  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        outp  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    outp  <= 1'b0;
                end
            endcase
        end
    end

    // Pending queue: a rise that launches in the same cycle is consumed
    // directly, so the count only moves on rise-only or launch-only.
    // A launch with an empty queue always has a rise, so no underflow.
    always_ff @(posedge cclk or posedge clr) begin
        if (clr) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            if (rise & ~launch) begin
                if (!sat) begin
                    pend <= pend + PEND_W'(1);
                end
            end else if (launch & ~rise) begin
                pend <= pend - PEND_W'(1);
            end

            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (rise & ~launch & sat) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
